// File: rtl/wb_arbiter.sv
// Two-lane writeback arbiter: per-lane FIFOs feeding one register-file
// write port with round-robin grant and a pending-destination scoreboard.
module wb_arbiter #(
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    input  logic [2:0]    in0_rd,
    input  logic [DW-1:0] in0_data,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [2:0]    in1_rd,
    input  logic [DW-1:0] in1_data,
    output logic          in1_ready,
    output logic          wb_en,
    output logic [2:0]    wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          wb_lane,
    output logic [7:0]    pending
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]    valid;
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    nempty;
    logic          any;
    logic          gnt;
    logic          last_grant;

    logic [2:0]    rd_in   [2];
    logic [DW-1:0] data_in [2];

    logic [2:0]    q_rd    [2][DEPTH];
    logic [DW-1:0] q_data  [2][DEPTH];
    logic [AW-1:0] wptr    [2];
    logic [AW-1:0] rptr    [2];
    logic [AW:0]   cnt     [2];

    assign valid      = {in1_valid, in0_valid};
    assign rd_in[0]   = in0_rd;
    assign rd_in[1]   = in1_rd;
    assign data_in[0] = in0_data;
    assign data_in[1] = in1_data;
    assign in0_ready  = ready[0];
    assign in1_ready  = ready[1];

    // ready looks only at the registered count, and is forced low in reset
    always_comb begin
        nempty = '0;
        ready  = '0;
        for (int l = 0; l < 2; l++) begin
            nempty[l] = (cnt[l] != '0);
            ready[l]  = rst_n && (cnt[l] != FULL);
        end
    end

    assign push = valid & ready;
    assign any  = |nempty;

    always_comb begin
        gnt = 1'b0;
        unique case (1'b1)
            &nempty:          gnt = ~last_grant;
            nempty == 2'b10:  gnt = 1'b1;
            default:          gnt = 1'b0;
        endcase
    end

    assign pop = {any & gnt, any & ~gnt};

    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) begin
                q_rd[l][wptr[l]]   <= rd_in[l];
                q_data[l][wptr[l]] <= data_in[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                wptr[l] <= '0;
                rptr[l] <= '0;
                cnt[l]  <= '0;
            end
            last_grant <= 1'b1;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_lane    <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push[l])
                    wptr[l] <= wptr[l] + 1'b1;
                if (pop[l])
                    rptr[l] <= rptr[l] + 1'b1;
                case ({push[l], pop[l]})
                    2'b10:   cnt[l] <= cnt[l] + 1'b1;
                    2'b01:   cnt[l] <= cnt[l] - 1'b1;
                    default: cnt[l] <= cnt[l];
                endcase
            end
            wb_en <= any;
            if (any) begin
                last_grant <= gnt;
                wb_rd      <= q_rd[gnt][rptr[gnt]];
                wb_data    <= q_data[gnt][rptr[gnt]];
                wb_lane    <= gnt;
            end
        end
    end

    // an entry is live when its offset from the read pointer is below count
    always_comb begin
        pending = '0;
        if (wb_en)
            pending[wb_rd] = 1'b1;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ({1'b0, AW'(i) - rptr[l]} < cnt[l])
                    pending[q_rd[l][i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed lane traffic, expected writes
// queued in hand-computed order and checked by an independent monitor.
module tb_wb_arbiter;

    typedef struct {
        logic        lane;
        logic [2:0]  rd;
        logic [15:0] data;
    } wb_t;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] data;
    } st_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in0_valid, in1_valid;
    logic [2:0]  in0_rd, in1_rd;
    logic [15:0] in0_data, in1_data;
    logic        in0_ready, in1_ready;
    logic        wb_en, wb_lane;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [7:0]  pending;

    int  checks = 0;
    int  errors = 0;
    wb_t exp_q[$];
    st_t s0[$];
    st_t s1[$];
    bit  stall1;
    wb_t mon_e;

    wb_arbiter #(.DW(16), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_rd    (in0_rd),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_rd    (in1_rd),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_lane   (wb_lane),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic expw(input logic l, input logic [2:0] r,
                        input logic [15:0] d);
        wb_t e;
        e.lane = l;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic st_t mk(input logic [2:0] r, input logic [15:0] d);
        st_t s;
        s.rd   = r;
        s.data = d;
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst_n && wb_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected lane %0d rd %0d data %h want none",
                         wb_lane, wb_rd, wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_lane", 32'(wb_lane), 32'(mon_e.lane));
                chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                chk("wb_data", 32'(wb_data), 32'(mon_e.data));
            end
        end
    end

    // called at a negedge; presents queued items and holds them until taken
    task automatic drive(input int budget);
        int   n = 0;
        logic v0, v1, r0, r1;
        stall1 = 1'b0;
        while ((s0.size() != 0 || s1.size() != 0) && n < budget) begin
            v0 = (s0.size() != 0);
            v1 = (s1.size() != 0);
            in0_valid = v0;
            in1_valid = v1;
            if (v0) begin
                in0_rd   = s0[0].rd;
                in0_data = s0[0].data;
            end
            if (v1) begin
                in1_rd   = s1[0].rd;
                in1_data = s1[0].data;
            end
            r0 = in0_ready;
            r1 = in1_ready;
            if (v1 && !r1)
                stall1 = 1'b1;
            @(posedge clk);
            if (v0 && r0)
                s0.delete(0);
            if (v1 && r1)
                s1.delete(0);
            @(negedge clk);
            in0_valid = 1'b0;
            in1_valid = 1'b0;
            n++;
        end
        chk("drive_left", 32'(s0.size() + s1.size()), 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wb_en) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 0);
    endtask

    task automatic tput();
        int n = 0;
        bit ok = 1'b1;
        while (!wb_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 8; k++) begin
            ok &= wb_en;
            @(negedge clk);
        end
        chk("throughput", 32'(ok), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_rd    = '0;
        in1_rd    = '0;
        in0_data  = '0;
        in1_data  = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wb_en", 32'(wb_en), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_wb_lane", 32'(wb_lane), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_ready", 32'({in1_ready, in0_ready}), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'({in1_ready, in0_ready}), 32'h3);
        @(negedge clk);

        // contention: lane 0 wins first, strict alternation, 1 write/cycle
        for (int i = 0; i < 4; i++) begin
            s0.push_back(mk(3'(i + 1), 16'hA000 + 16'(i)));
            s1.push_back(mk(3'(i + 4), 16'hB000 + 16'(i)));
            expw(1'b0, 3'(i + 1), 16'hA000 + 16'(i));
            expw(1'b1, 3'(i + 4), 16'hB000 + 16'(i));
        end
        fork
            drive(30);
            tput();
        join
        drain();

        // same destination in both lanes, last_grant = 1
        s0.push_back(mk(3'd5, 16'hAAAA));
        s1.push_back(mk(3'd5, 16'hBBBB));
        expw(1'b0, 3'd5, 16'hAAAA);
        expw(1'b1, 3'd5, 16'hBBBB);
        drive(5);
        chk("same_pend_q", 32'(pending[5]), 1);
        @(negedge clk);
        chk("same_pend_wb1", 32'(pending[5]), 1);
        @(negedge clk);
        chk("same_pend_wb2", 32'(pending[5]), 1);
        @(negedge clk);
        chk("same_pend_clr", 32'(pending[5]), 0);
        drain();

        // lane 1 fills and is back-pressured while lane 0 saturates
        for (int i = 0; i < 6; i++)
            s0.push_back(mk(3'(i), 16'hC000 + 16'(i)));
        for (int i = 0; i < 3; i++)
            s1.push_back(mk(3'(7 - i), 16'hD000 + 16'(i)));
        for (int i = 0; i < 3; i++) begin
            expw(1'b0, 3'(i), 16'hC000 + 16'(i));
            expw(1'b1, 3'(7 - i), 16'hD000 + 16'(i));
        end
        for (int i = 3; i < 6; i++)
            expw(1'b0, 3'(i), 16'hC000 + 16'(i));
        drive(30);
        chk("full_stall1", 32'(stall1), 1);
        drain();

        // single write: latency and pending window
        in0_valid = 1'b1;
        in0_rd    = 3'd3;
        in0_data  = 16'h1234;
        expw(1'b0, 3'd3, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        in0_valid = 1'b0;
        chk("single_pend_n", 32'(pending[3]), 1);
        chk("single_lat_en", 32'(wb_en), 0);
        @(negedge clk);
        chk("single_wb_en", 32'(wb_en), 1);
        chk("single_pend_wb", 32'(pending[3]), 1);
        @(negedge clk);
        chk("single_pend_clr", 32'(pending[3]), 0);
        chk("single_en_clr", 32'(wb_en), 0);

        // idle: outputs hold the last write
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_en", 32'(wb_en), 0);
            chk("idle_rd", 32'(wb_rd), 3);
            chk("idle_data", 32'(wb_data), 32'h1234);
        end

        // last_grant held at 0 across idle, so lane 1 goes first
        s0.push_back(mk(3'd1, 16'h1111));
        s1.push_back(mk(3'd2, 16'h2222));
        expw(1'b1, 3'd2, 16'h2222);
        expw(1'b0, 3'd1, 16'h1111);
        drive(5);
        drain();

        // reset in flight discards everything queued
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_rd    = 3'd1;
        in0_data  = 16'h5550;
        in1_rd    = 3'd2;
        in1_data  = 16'h6660;
        @(posedge clk);
        @(negedge clk);
        in0_rd    = 3'd3;
        in0_data  = 16'h5551;
        in1_rd    = 3'd4;
        in1_data  = 16'h6661;
        @(posedge clk);
        #1;
        chk("mid_wb_en", 32'(wb_en), 1);
        chk("mid_pend_nz", 32'(pending != 8'h00), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(wb_en), 0);
        chk("mid_rst_pend", 32'(pending), 0);
        chk("mid_rst_ready", 32'({in1_ready, in0_ready}), 0);
        @(negedge clk);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_en)
                stale++;
        end
        chk("stale_writes", 32'(stale), 0);
        chk("stale_pend", 32'(pending), 0);

        chk("exp_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
